// File: rtl/mips_mem_pkg.sv
// Shared types and default constants for the MIPS data-memory access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_mem_pkg;

    // Default memory map: data memory word 0 sits at byte address 1024
    localparam int DEF_BASE_ADDR = 1024;
    localparam int DEF_DEPTH     = 512;
    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_TIMEOUT   = 15;

    // Width of the ACCESS wait counter; TIMEOUT must fit in it
    localparam int CNT_W         = 4;
    localparam int DATA_W        = 32;

    // Controller sequencing: IDLE -> (ACCESS) -> DONE -> IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_addr_decode.sv
// Byte address to data-memory word index with range/alignment check.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module mem_addr_decode
    import mips_mem_pkg::*;
#(
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic [31:0]       i_byte_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_word_idx
);

    localparam logic [31:0] BASE_L = 32'(BASE_ADDR);
    localparam logic [31:0] SPAN_L = 32'(4 * DEPTH);

    logic [31:0] w_off;

    // The lower-bound compare catches wrap-around of the subtraction, the
    // upper-bound compare is done on the offset so BASE+SPAN never overflows.
    always_comb begin
        w_off      = i_byte_addr - BASE_L;
        o_valid    = (i_byte_addr >= BASE_L) &&
                     (w_off < SPAN_L) &&
                     (i_byte_addr[1:0] == 2'b00);
        o_word_idx = w_off[ADDR_W+1:2];
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns a load/store into a held mem_req handshake, freezing the pipeline meanwhile.
// Latency: best case 3 cycles (detect, one ACCESS with ack, DONE); worst case TIMEOUT+3 cycles.
// Backpressure: freeze stalls upstream from the detect cycle until DONE; memory stalls us by withholding mem_ack.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_result,
    input  logic [31:0]       ST_val,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              freeze,
    output logic [31:0]       Mem_read_value,
    output logic              mem_err
);

    localparam logic [CNT_W-1:0] TMO_L = CNT_W'(TIMEOUT);

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fault;
    logic [31:0]       r_rdval;

    logic              w_en;
    logic              w_valid;
    logic [ADDR_W-1:0] w_idx;
    logic              w_timeout;
    logic              w_freeze;
    logic              w_req;

    assign w_en      = MEM_R_EN | MEM_W_EN;
    assign w_timeout = (r_cnt == TMO_L);

    // Decode the live address; the index is latched in the detect cycle
    mem_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_decode (
        .i_byte_addr (ALU_result),
        .o_valid     (w_valid),
        .o_word_idx  (w_idx)
    );

    // State register; reset aborts any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus freeze/mem_req; freeze rises in the detect cycle itself
    always_comb begin
        w_state_nxt = r_state;
        w_freeze    = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_en) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = w_valid ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                w_freeze = 1'b1;
                w_req    = 1'b1;
                // ack wins over a simultaneous timeout
                if (mem_ack || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, wait counter, fault flag and load result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_rdval <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_en) begin
                        // A store wins when both enables are set
                        r_we    <= MEM_W_EN;
                        r_addr  <= w_idx;
                        r_wdata <= ST_val;
                        r_cnt   <= '0;
                        r_fault <= ~w_valid;
                        if (!w_valid && !MEM_W_EN) begin
                            r_rdval <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        r_fault <= 1'b0;
                        if (!r_we) begin
                            r_rdval <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        if (!r_we) begin
                            r_rdval <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign freeze         = w_freeze;
    assign mem_req        = w_req;
    assign mem_we         = r_we;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign Mem_read_value = r_rdval;
    assign mem_err        = (r_state == DONE) && r_fault;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses, monitor checks each DONE cycle.
// Latency: clock period 10; inputs driven 1 after rising edge, outputs sampled on falling edge.
// Backpressure: bench acts as the memory and chooses the ack cycle per access.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] ST_val;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        freeze;
    logic [31:0] Mem_read_value;
    logic        mem_err;

    typedef struct {
        logic        err;
        logic [31:0] rdval;
        int          req_cycles;
        int          frz_cycles;
        logic [8:0]  addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    int   n_chk;
    int   n_fail;

    int   frz_cnt;
    int   req_cnt;
    int   addr_bad;
    int   we_bad;
    int   wd_bad;
    logic prev_frz;

    mem_access_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_R_EN       (MEM_R_EN),
        .MEM_W_EN       (MEM_W_EN),
        .ALU_result     (ALU_result),
        .ST_val         (ST_val),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .freeze         (freeze),
        .Mem_read_value (Mem_read_value),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a falling freeze marks the DONE cycle of an access
    always @(negedge clk) begin
        if (!rst) begin
            frz_cnt  = 0;
            req_cnt  = 0;
            addr_bad = 0;
            we_bad   = 0;
            wd_bad   = 0;
            prev_frz = 1'b0;
        end else begin
            if (freeze) frz_cnt++;
            if (mem_req) begin
                req_cnt++;
                if (exp_q.size() > 0) begin
                    if (mem_addr !== exp_q[0].addr) addr_bad++;
                    if (mem_we !== exp_q[0].we) we_bad++;
                    if (exp_q[0].we && (mem_wdata !== exp_q[0].wdata)) wd_bad++;
                end
            end
            if (mem_req && !freeze) check("req_without_freeze", 32'(mem_req), 32'd0);
            if (prev_frz && !freeze) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_mem_err", 32'(mem_err), 32'(e.err));
                    check("done_read_value", Mem_read_value, e.rdval);
                    check("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
                    check("freeze_cycles", 32'(frz_cnt), 32'(e.frz_cycles));
                    if (e.req_cycles > 0) begin
                        check("addr_bad_cycles", 32'(addr_bad), 32'd0);
                        check("we_bad_cycles", 32'(we_bad), 32'd0);
                        if (e.we) check("wdata_bad_cycles", 32'(wd_bad), 32'd0);
                    end
                end
                frz_cnt  = 0;
                req_cnt  = 0;
                addr_bad = 0;
                we_bad   = 0;
                wd_bad   = 0;
            end else if (mem_err) begin
                check("err_outside_done", 32'(mem_err), 32'd0);
            end
            prev_frz = freeze;
        end
    end

    // Issue one access and act as memory; ack_at < 0 means never ack
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata,
                             input logic exp_err, input logic [31:0] exp_rdval,
                             input int exp_req, input logic [8:0] exp_addr);
        exp_t e;
        int   k;
        e.err        = exp_err;
        e.rdval      = exp_rdval;
        e.req_cycles = exp_req;
        e.frz_cycles = exp_req + 1;
        e.addr       = exp_addr;
        e.we         = wr;
        e.wdata      = wdata;
        exp_q.push_back(e);

        MEM_R_EN   = rd;
        MEM_W_EN   = wr;
        ALU_result = addr;
        ST_val     = wdata;
        @(posedge clk); #1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        k = 0;
        while (mem_req && k < 40) begin
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rdata : 32'hDEAD_BEEF;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            k++;
        end
        if (k >= 40) check("access_bound", 32'(k), 32'(exp_req));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = 32'd0;
        ST_val     = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        #1 rst = 1'b0;
        #2;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_read_value", Mem_read_value, 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        #19 rst = 1'b1;
        @(posedge clk); #1;

        // rd wr  addr   wdata          ack  rdata          err  rdval          req addr
        do_access(0, 1, 1032, 32'hCAFEF00D, 1, 32'h0,          0, 32'h0,          2,  9'd2);
        do_access(1, 0, 1024, 32'h0,        0, 32'h12345678,   0, 32'h12345678,   1,  9'd0);
        do_access(1, 0, 1026, 32'h0,        0, 32'h0,          1, 32'h0,          0,  9'd0);
        do_access(1, 0, 1028, 32'h0,        0, 32'hA5A50001,   0, 32'hA5A50001,   1,  9'd1);
        do_access(1, 0, 3072, 32'h0,        0, 32'h0,          1, 32'h0,          0,  9'd0);
        do_access(1, 0, 3068, 32'h0,        2, 32'h0BADC0DE,   0, 32'h0BADC0DE,   3,  9'd511);
        do_access(1, 0, 1100, 32'h0,       -1, 32'h0,          1, 32'h0,          16, 9'd19);
        do_access(1, 0, 1100, 32'h0,       15, 32'h00F0F0F0,   0, 32'h00F0F0F0,   16, 9'd19);
        do_access(1, 1, 1028, 32'h11112222, 0, 32'h0,          0, 32'h00F0F0F0,   1,  9'd1);
        do_access(0, 1, 1020, 32'h33334444, 0, 32'h0,          1, 32'h00F0F0F0,   0,  9'd0);

        // A stray ack while idle must not disturb anything
        mem_ack   = 1'b1;
        mem_rdata = 32'hBADBAD00;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        check("idle_ack_read_value", Mem_read_value, 32'h00F0F0F0);
        check("idle_ack_mem_req", 32'(mem_req), 32'd0);
        check("idle_ack_freeze", 32'(freeze), 32'd0);

        // Reset in the middle of an ACCESS
        MEM_R_EN   = 1'b1;
        ALU_result = 32'd1040;
        @(posedge clk); #1;
        MEM_R_EN   = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        check("pre_rst_mem_addr", 32'(mem_addr), 32'd4);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_freeze", 32'(freeze), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_read_value", Mem_read_value, 32'd0);
        check("mid_rst_mem_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle_req", 32'(mem_req), 32'd0);
        do_access(1, 0, 1040, 32'h0, 0, 32'h00000077, 0, 32'h00000077, 1, 9'd4);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 1024, SHALL be the byte address of data-memory word 0.
REQ-002 Parameter DEPTH, default 512, SHALL be the data-memory size in 32-bit words.
REQ-003 Parameter ADDR_W, default 9, SHALL be the word-index width, log2(DEPTH).
REQ-004 Parameter TIMEOUT, default 15, SHALL be the maximum number of ACCESS cycles waited for mem_ack.
REQ-005 Port list SHALL be:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- MEM_R_EN  in  1  load request from EXE/MEM register.
- MEM_W_EN  in  1  store request from EXE/MEM register.
- ALU_result  in  32  byte address.
- ST_val  in  32  store data.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  ADDR_W  word index.
- mem_wdata  out  32  store data.
- mem_ack  in  1  one-cycle completion pulse from memory.
- mem_rdata  in  32  read data; valid with mem_ack.
- freeze  out  1  stall for IF/ID/EXE and pipeline registers.
- Mem_read_value  out  32  load result to MEM/WB.
- mem_err  out  1  access-fault pulse.

Function
REQ-006 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-007 IDLE with neither enable set SHALL stay in IDLE, freeze = 0, mem_req = 0.
REQ-008 IDLE with either enable set SHALL assert freeze combinationally in that same cycle.
REQ-009 IDLE with either enable set SHALL latch the address, ST_val and direction into internal registers.
REQ-010 IDLE with either enable set SHALL go to ACCESS if the address is valid, else go to DONE.
REQ-011 An address SHALL be valid iff BASE_ADDR <= ALU_result < BASE_ADDR + 4*DEPTH and ALU_result[1:0] == 0.
REQ-012 mem_addr SHALL equal (latched address - BASE_ADDR) >> 2, truncated to ADDR_W bits.
REQ-013 If MEM_R_EN and MEM_W_EN are both 1, the access SHALL be a write.
REQ-014 ACCESS SHALL assert freeze = 1 and mem_req = 1.
REQ-015 In ACCESS, mem_we, mem_addr and mem_wdata SHALL be driven from the latched registers and held stable.
REQ-016 A 4-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ack.
REQ-017 mem_ack in ACCESS SHALL capture mem_rdata into Mem_read_value on a read, leave it unchanged on a write, and go to DONE.
REQ-018 A count equal to TIMEOUT with no mem_ack SHALL go to DONE with a fault.
REQ-019 mem_ack arriving in the same cycle the count equals TIMEOUT SHALL win: no fault.
REQ-020 DONE SHALL last exactly one cycle with freeze = 0 and mem_req = 0, then return to IDLE.
REQ-021 mem_err SHALL be 1 only in DONE of a faulted access (invalid address or timeout).
REQ-022 A faulted read SHALL load Mem_read_value with 32'h0.
REQ-023 Mem_read_value SHALL hold its value until the next completed read.
REQ-024 mem_ack outside ACCESS SHALL be ignored.
REQ-025 Best-case latency SHALL be 3 cycles from IDLE detect to DONE, with mem_ack in the first ACCESS cycle.

Reset
REQ-026 rst = 0 SHALL immediately force IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, freeze = 0, Mem_read_value = 0, mem_err = 0 and counter = 0, including mid-ACCESS.
REQ-027 After rst rises, the first sampled enable SHALL start a fresh access; no aborted access is resumed.

Structure
REQ-028 Package mips_mem_pkg SHALL hold the FSM state typedef and the BASE_ADDR, DEPTH, ADDR_W and TIMEOUT default constants.
REQ-029 Address range check and index computation SHALL live in one combinational sub-module, mem_addr_decode (in: byte address; out: valid, word index).
REQ-030 The top level SHALL hold the FSM, wait counter and output registers only.

Verification
REQ-031 Bench SHALL cover: MEM_W_EN = 1, ALU_result = 1032, ST_val = 32'hCAFEF00D, mem_ack on 2nd ACCESS cycle -> mem_addr = 2, mem_we = 1, freeze high for 3 cycles, mem_err = 0.
REQ-032 Bench SHALL cover: MEM_R_EN = 1, ALU_result = 1024, mem_ack first cycle with mem_rdata = 32'h12345678 -> Mem_read_value = 32'h12345678 in DONE, mem_addr = 0.
REQ-033 Bench SHALL cover: MEM_R_EN = 1, ALU_result = 1026 (misaligned) and separately 3072 (out of range) -> no mem_req, DONE next cycle, mem_err = 1, Mem_read_value = 0.
REQ-034 Bench SHALL cover: MEM_R_EN = 1, valid address, no mem_ack -> mem_req held 16 cycles, then DONE with mem_err = 1; repeat with mem_ack on the count = 15 cycle -> mem_err = 0.
REQ-035 Bench SHALL cover: both enables set, ALU_result = 1028 -> mem_we = 1, mem_addr = 1.
REQ-036 Bench SHALL cover: rst low during ACCESS -> mem_req and freeze drop asynchronously; next access after release completes normally.
